dot_product_ctrl: RTL and testbench
===================================

Name: dot_product_ctrl

Overview:
Sequencing engine for the dot-product accelerator. Takes configuration from the AXI-Lite register block: control/start, vector A base, vector B base, vector length and output address. Acts as an AXI-Lite master: fetches A[i] and B[i] element by element, multiply-accumulates them, and writes the result to the output address. Reports busy/done/error back for the status register.

Parameters:
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 32, AXI data / element width
ACC_WIDTH, 64, accumulator width; must be ≥ 2*DATA_WIDTH
LEN_WIDTH, 16, element-count width

Ports:
ACLK  in  1  clock
ARESETN  in  1  async active-low reset
start  in  1  one-cycle start pulse (REG0 bit0 edge)
vec_a_base  in  ADDR_WIDTH  byte address of A[0]
vec_b_base  in  ADDR_WIDTH  byte address of B[0]
vec_len  in  LEN_WIDTH  element count N
out_addr  in  ADDR_WIDTH  result byte address
busy  out  1  high from accepted start until done
done  out  1  sticky completion flag
error  out  1  sticky; non-OKAY response seen
result  out  DATA_WIDTH  low DATA_WIDTH bits of final accumulator
M_ARADDR/M_ARVALID out, M_ARREADY in  read-address channel
M_RDATA/M_RRESP in, M_RVALID in, M_RREADY out  read-data channel
M_AWADDR/M_AWVALID out, M_AWREADY in  write-address channel
M_WDATA/M_WVALID out, M_WREADY in, M_WSTRB out (4'hF)  write-data channel
M_BRESP/M_BVALID in, M_BREADY out  write-response channel

Behaviour:
- Reset is asynchronous, active-low on ARESETN; clock is ACLK.
- Reset values: all VALID/READY outputs 0; busy, done and error 0; result 0; addresses 0; state IDLE.
- A reset mid-operation aborts immediately. No handshake completes.
- States: IDLE, RD_A_AR, RD_A_R, RD_B_AR, RD_B_R, MAC, WR_AW_W, WR_B.
- IDLE:
  - start=1 latches base A, base B, length and out_addr.
  - Clears acc, index, done and error; sets busy.
  - Goes to RD_A_AR if vec_len≠0, else WR_AW_W (writes 0).
- start is ignored while busy=1.
- RD_x_AR:
  - Drive ARADDR = base_x + 4*idx and ARVALID=1.
  - ARADDR stays stable until ARREADY is sampled high.
  - After the handshake, drop ARVALID and go to RD_x_R.
- RD_x_R:
  - RREADY=1. On RVALID, capture RDATA into opA/opB.
  - A goes to RD_B_AR; B goes to MAC.
  - RRESP≠2'b00: set error, done=1, busy=0, back to IDLE; no write is issued.
- MAC:
  - acc <= acc + signed(opA)*signed(opB), sign-extended to ACC_WIDTH; overflow wraps silently.
  - idx <= idx+1.
  - If idx+1 == len go to WR_AW_W, else RD_A_AR.
- WR_AW_W:
  - Assert AWVALID (AWADDR=out_addr) and WVALID (WDATA=acc[DATA_WIDTH-1:0]) together.
  - Each VALID drops independently after its own handshake.
  - Leave the state when both have completed, in either order or the same cycle.
- WR_B:
  - BREADY=1. On BVALID, result <= acc low bits; done=1; busy=0; go to IDLE.
  - BRESP≠OKAY also sets error.
- Never assert ARVALID and AWVALID at once.
- Minimum per-element cost is 5 cycles with zero-wait slaves.
- Address arithmetic wraps modulo 2^ADDR_WIDTH.
- A start in the same cycle done is set is ignored, because busy is still 1.

Test Plan:
- A=[1,2,3] at 0x0, B=[4,5,6] at 0x100, len=3, out=0x1000 -> ARADDR order 0x0,0x100,0x4,0x104,0x8,0x108; write 32 to 0x1000; done=1, error=0, result=32.
- len=0, out=0x2000 -> no AR traffic; write 0 to 0x2000; done=1.
- A=[-2], B=[7] (0xFFFFFFFE, 7) -> WDATA=0xFFFFFFF2.
- Read slave returns RRESP=2'b10 on the B[1] fetch -> error=1, done=1, no AW/W issued, busy=0.
- Slave holds ARREADY/AWREADY low 3 cycles, WREADY before AWREADY -> ARADDR/AWADDR stable throughout; WVALID drops first; result still correct.
- ARESETN low mid-RD_B_R, then start again with len=1 -> all VALIDs 0 during reset; second run completes correctly.

Source files
------------

// File: rtl/dot_product_ctrl_if.sv
// AXI-Lite master bundle used by the dot-product sequencing engine.
// The master drives the address/data/valid outputs and the ready signals for
// the R and B channels. The slave drives the ready signals for AR/AW/W and the
// R/B responses.
interface dot_product_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   M_ARADDR;
    logic                    M_ARVALID;
    logic                    M_ARREADY;

    logic [DATA_WIDTH-1:0]   M_RDATA;
    logic [1:0]              M_RRESP;
    logic                    M_RVALID;
    logic                    M_RREADY;

    logic [ADDR_WIDTH-1:0]   M_AWADDR;
    logic                    M_AWVALID;
    logic                    M_AWREADY;

    logic [DATA_WIDTH-1:0]   M_WDATA;
    logic [DATA_WIDTH/8-1:0] M_WSTRB;
    logic                    M_WVALID;
    logic                    M_WREADY;

    logic [1:0]              M_BRESP;
    logic                    M_BVALID;
    logic                    M_BREADY;

    modport master (
        output M_ARADDR, M_ARVALID, input M_ARREADY,
        input  M_RDATA, M_RRESP, M_RVALID, output M_RREADY,
        output M_AWADDR, M_AWVALID, input M_AWREADY,
        output M_WDATA, M_WSTRB, M_WVALID, input M_WREADY,
        input  M_BRESP, M_BVALID, output M_BREADY
    );

    modport slave (
        input  M_ARADDR, M_ARVALID, output M_ARREADY,
        output M_RDATA, M_RRESP, M_RVALID, input M_RREADY,
        input  M_AWADDR, M_AWVALID, output M_AWREADY,
        input  M_WDATA, M_WSTRB, M_WVALID, output M_WREADY,
        output M_BRESP, M_BVALID, input M_BREADY
    );
endinterface

// File: rtl/dot_product_ctrl.sv
// Dot-product sequencing engine. On start it fetches A[i] and B[i] one element
// at a time over AXI-Lite, multiply-accumulates them as signed values, and
// writes the low DATA_WIDTH bits of the accumulator to the output address.
// Only one AXI transaction is ever outstanding, so AR and AW never overlap.
// ACC_WIDTH must be at least 2*DATA_WIDTH so a single product is exact.
module dot_product_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 64,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] vec_a_base,
    input  logic [ADDR_WIDTH-1:0] vec_b_base,
    input  logic [LEN_WIDTH-1:0]  vec_len,
    input  logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [DATA_WIDTH-1:0] result,
    dot_product_ctrl_if.master    m_axi
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_A_AR = 3'd1,
        RD_A_R  = 3'd2,
        RD_B_AR = 3'd3,
        RD_B_R  = 3'd4,
        MAC     = 3'd5,
        WR_AW_W = 3'd6,
        WR_B    = 3'd7
    } state_t;

    localparam logic [LEN_WIDTH-1:0] IDX_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [LEN_WIDTH-1:0] IDX_ZERO = {LEN_WIDTH{1'b0}};

    // Byte address of element idx, wrapping modulo 2^ADDR_WIDTH.
    function automatic logic [ADDR_WIDTH-1:0] elem_addr(
        input logic [ADDR_WIDTH-1:0] base,
        input logic [LEN_WIDTH-1:0]  idx
    );
        logic [ADDR_WIDTH+LEN_WIDTH+1:0] sum;
        sum = {{(LEN_WIDTH+2){1'b0}}, base} + {{ADDR_WIDTH{1'b0}}, idx, 2'b00};
        return sum[ADDR_WIDTH-1:0];
    endfunction

    state_t                 state_r;
    logic [ADDR_WIDTH-1:0]  base_a_r;
    logic [ADDR_WIDTH-1:0]  base_b_r;
    logic [LEN_WIDTH-1:0]   len_r;
    logic [ADDR_WIDTH-1:0]  out_addr_r;
    logic [LEN_WIDTH-1:0]   idx_r;
    logic [DATA_WIDTH-1:0]  opa_r;
    logic [DATA_WIDTH-1:0]  opb_r;
    logic [ACC_WIDTH-1:0]   acc_r;

    logic                   busy_r;
    logic                   done_r;
    logic                   error_r;
    logic [DATA_WIDTH-1:0]  result_r;

    logic [ADDR_WIDTH-1:0]  araddr_r;
    logic                   arvalid_r;
    logic                   rready_r;
    logic [ADDR_WIDTH-1:0]  awaddr_r;
    logic                   awvalid_r;
    logic [DATA_WIDTH-1:0]  wdata_r;
    logic                   wvalid_r;
    logic                   bready_r;

    logic [ACC_WIDTH-1:0]   opa_ext_s;
    logic [ACC_WIDTH-1:0]   opb_ext_s;
    logic [ACC_WIDTH-1:0]   prod_s;
    logic [ACC_WIDTH-1:0]   acc_sum_s;
    logic [LEN_WIDTH-1:0]   idx_inc_s;
    logic                   aw_done_s;
    logic                   w_done_s;

    // Operands are sign-extended to the accumulator width; the truncated
    // product is exact because ACC_WIDTH >= 2*DATA_WIDTH.
    assign opa_ext_s = {{(ACC_WIDTH-DATA_WIDTH){opa_r[DATA_WIDTH-1]}}, opa_r};
    assign opb_ext_s = {{(ACC_WIDTH-DATA_WIDTH){opb_r[DATA_WIDTH-1]}}, opb_r};
    assign prod_s    = opa_ext_s * opb_ext_s;
    assign acc_sum_s = acc_r + prod_s;
    assign idx_inc_s = idx_r + IDX_ONE;

    // A write channel counts as finished once its VALID has been dropped or
    // its handshake completes this cycle.
    assign aw_done_s = !awvalid_r || m_axi.M_AWREADY;
    assign w_done_s  = !wvalid_r  || m_axi.M_WREADY;

    assign busy   = busy_r;
    assign done   = done_r;
    assign error  = error_r;
    assign result = result_r;

    assign m_axi.M_ARADDR  = araddr_r;
    assign m_axi.M_ARVALID = arvalid_r;
    assign m_axi.M_RREADY  = rready_r;
    assign m_axi.M_AWADDR  = awaddr_r;
    assign m_axi.M_AWVALID = awvalid_r;
    assign m_axi.M_WDATA   = wdata_r;
    assign m_axi.M_WSTRB   = {(DATA_WIDTH/8){1'b1}};
    assign m_axi.M_WVALID  = wvalid_r;
    assign m_axi.M_BREADY  = bready_r;

    // Sequencer: state, datapath and every bus/status output are registered here.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_r    <= IDLE;
            base_a_r   <= {ADDR_WIDTH{1'b0}};
            base_b_r   <= {ADDR_WIDTH{1'b0}};
            len_r      <= {LEN_WIDTH{1'b0}};
            out_addr_r <= {ADDR_WIDTH{1'b0}};
            idx_r      <= {LEN_WIDTH{1'b0}};
            opa_r      <= {DATA_WIDTH{1'b0}};
            opb_r      <= {DATA_WIDTH{1'b0}};
            acc_r      <= {ACC_WIDTH{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
            result_r   <= {DATA_WIDTH{1'b0}};
            araddr_r   <= {ADDR_WIDTH{1'b0}};
            arvalid_r  <= 1'b0;
            rready_r   <= 1'b0;
            awaddr_r   <= {ADDR_WIDTH{1'b0}};
            awvalid_r  <= 1'b0;
            wdata_r    <= {DATA_WIDTH{1'b0}};
            wvalid_r   <= 1'b0;
            bready_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        base_a_r   <= vec_a_base;
                        base_b_r   <= vec_b_base;
                        len_r      <= vec_len;
                        out_addr_r <= out_addr;
                        acc_r      <= {ACC_WIDTH{1'b0}};
                        idx_r      <= {LEN_WIDTH{1'b0}};
                        done_r     <= 1'b0;
                        error_r    <= 1'b0;
                        busy_r     <= 1'b1;
                        if (vec_len != IDX_ZERO) begin
                            araddr_r  <= vec_a_base;
                            arvalid_r <= 1'b1;
                            state_r   <= RD_A_AR;
                        end else begin
                            // Empty vectors still produce a write of zero.
                            awaddr_r  <= out_addr;
                            awvalid_r <= 1'b1;
                            wdata_r   <= {DATA_WIDTH{1'b0}};
                            wvalid_r  <= 1'b1;
                            state_r   <= WR_AW_W;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end

                RD_A_AR: begin
                    if (m_axi.M_ARREADY) begin
                        arvalid_r <= 1'b0;
                        rready_r  <= 1'b1;
                        state_r   <= RD_A_R;
                    end else begin
                        state_r <= RD_A_AR;
                    end
                end

                RD_A_R: begin
                    if (m_axi.M_RVALID) begin
                        rready_r <= 1'b0;
                        if (m_axi.M_RRESP != 2'b00) begin
                            error_r <= 1'b1;
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                            state_r <= IDLE;
                        end else begin
                            opa_r     <= m_axi.M_RDATA;
                            araddr_r  <= elem_addr(base_b_r, idx_r);
                            arvalid_r <= 1'b1;
                            state_r   <= RD_B_AR;
                        end
                    end else begin
                        state_r <= RD_A_R;
                    end
                end

                RD_B_AR: begin
                    if (m_axi.M_ARREADY) begin
                        arvalid_r <= 1'b0;
                        rready_r  <= 1'b1;
                        state_r   <= RD_B_R;
                    end else begin
                        state_r <= RD_B_AR;
                    end
                end

                RD_B_R: begin
                    if (m_axi.M_RVALID) begin
                        rready_r <= 1'b0;
                        if (m_axi.M_RRESP != 2'b00) begin
                            error_r <= 1'b1;
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                            state_r <= IDLE;
                        end else begin
                            opb_r   <= m_axi.M_RDATA;
                            state_r <= MAC;
                        end
                    end else begin
                        state_r <= RD_B_R;
                    end
                end

                MAC: begin
                    acc_r <= acc_sum_s;
                    idx_r <= idx_inc_s;
                    if (idx_inc_s == len_r) begin
                        awaddr_r  <= out_addr_r;
                        awvalid_r <= 1'b1;
                        wdata_r   <= acc_sum_s[DATA_WIDTH-1:0];
                        wvalid_r  <= 1'b1;
                        state_r   <= WR_AW_W;
                    end else begin
                        araddr_r  <= elem_addr(base_a_r, idx_inc_s);
                        arvalid_r <= 1'b1;
                        state_r   <= RD_A_AR;
                    end
                end

                WR_AW_W: begin
                    if (awvalid_r && m_axi.M_AWREADY) begin
                        awvalid_r <= 1'b0;
                    end else begin
                        awvalid_r <= awvalid_r;
                    end
                    if (wvalid_r && m_axi.M_WREADY) begin
                        wvalid_r <= 1'b0;
                    end else begin
                        wvalid_r <= wvalid_r;
                    end
                    if (aw_done_s && w_done_s) begin
                        bready_r <= 1'b1;
                        state_r  <= WR_B;
                    end else begin
                        state_r <= WR_AW_W;
                    end
                end

                WR_B: begin
                    if (m_axi.M_BVALID) begin
                        bready_r <= 1'b0;
                        result_r <= acc_r[DATA_WIDTH-1:0];
                        done_r   <= 1'b1;
                        busy_r   <= 1'b0;
                        if (m_axi.M_BRESP != 2'b00) begin
                            error_r <= 1'b1;
                        end else begin
                            error_r <= error_r;
                        end
                        state_r <= IDLE;
                    end else begin
                        state_r <= WR_B;
                    end
                end

                default: begin
                    // Unreachable encoding: park safely with the bus quiet.
                    arvalid_r <= 1'b0;
                    rready_r  <= 1'b0;
                    awvalid_r <= 1'b0;
                    wvalid_r  <= 1'b0;
                    bready_r  <= 1'b0;
                    busy_r    <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dot_product_ctrl.sv
// Self-checking bench for dot_product_ctrl: a reactive AXI-Lite memory slave
// with programmable stalls, a bus monitor, and a plain-arithmetic reference
// model of the dot product and of the expected read-address sequence.
module tb_dot_product_ctrl;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic        start = 1'b0;
    logic [31:0] vec_a_base = 32'd0;
    logic [31:0] vec_b_base = 32'd0;
    logic [15:0] vec_len = 16'd0;
    logic [31:0] out_addr = 32'd0;
    logic        busy, done, error;
    logic [31:0] result;

    dot_product_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    dot_product_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ACC_WIDTH(64), .LEN_WIDTH(16)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .start(start),
        .vec_a_base(vec_a_base), .vec_b_base(vec_b_base), .vec_len(vec_len),
        .out_addr(out_addr), .busy(busy), .done(done), .error(error),
        .result(result), .m_axi(bus)
    );

    always #5 ACLK = ~ACLK;

    int total = 0;
    int bad = 0;

    bit [31:0] mem [bit [31:0]];
    bit [31:0] ar_log[$];
    bit [31:0] wr_addr_q[$];
    bit [31:0] wr_data_q[$];
    int        ar_delay = 0, aw_delay = 0, w_delay = 0;
    bit        err_en = 1'b0;
    bit [31:0] err_addr = 32'd0;
    bit [1:0]  bresp_val = 2'b00;
    int        cyc = 0, aw_cyc = 0, w_cyc = 0;
    int        excl_viol = 0, stab_viol = 0;

    // Slave + monitor: everything is evaluated on the falling edge, where DUT
    // outputs are stable; *_hs flags remember what will handshake at the next
    // rising edge so it can be acted on one negedge later.
    initial begin : slave
        bit ar_hs, r_hs, aw_hs, w_hs, b_hs, aw_got, w_got, ar_pend, aw_pend;
        bit [31:0] ar_hs_addr, ar_pend_addr, aw_hs_addr, aw_pend_addr, w_hs_data;
        int ar_cnt, aw_cnt, w_cnt;
        bus.M_ARREADY = 1'b0; bus.M_RVALID = 1'b0; bus.M_RDATA = 32'd0; bus.M_RRESP = 2'b00;
        bus.M_AWREADY = 1'b0; bus.M_WREADY = 1'b0; bus.M_BVALID = 1'b0; bus.M_BRESP = 2'b00;
        ar_hs = 0; r_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0; aw_got = 0; w_got = 0;
        ar_pend = 0; aw_pend = 0; ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
        ar_hs_addr = 0; ar_pend_addr = 0; aw_hs_addr = 0; aw_pend_addr = 0; w_hs_data = 0;
        forever begin
            @(negedge ACLK);
            cyc++;
            if (!ARESETN) begin
                bus.M_ARREADY = 1'b0; bus.M_RVALID = 1'b0; bus.M_AWREADY = 1'b0;
                bus.M_WREADY = 1'b0; bus.M_BVALID = 1'b0;
                ar_hs = 0; r_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0; aw_got = 0; w_got = 0;
                ar_pend = 0; aw_pend = 0; ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
                continue;
            end
            if (bus.M_ARVALID && bus.M_AWVALID) excl_viol++;
            if (ar_pend && (!bus.M_ARVALID || bus.M_ARADDR != ar_pend_addr)) stab_viol++;
            if (aw_pend && (!bus.M_AWVALID || bus.M_AWADDR != aw_pend_addr)) stab_viol++;
            if (r_hs) bus.M_RVALID = 1'b0;
            if (ar_hs) begin
                ar_log.push_back(ar_hs_addr);
                bus.M_ARREADY = 1'b0;
                ar_cnt = 0;
                bus.M_RVALID = 1'b1;
                bus.M_RDATA = mem.exists(ar_hs_addr) ? mem[ar_hs_addr] : 32'd0;
                bus.M_RRESP = (err_en && ar_hs_addr == err_addr) ? 2'b10 : 2'b00;
            end
            if (b_hs) bus.M_BVALID = 1'b0;
            if (aw_hs) begin
                wr_addr_q.push_back(aw_hs_addr);
                bus.M_AWREADY = 1'b0; aw_cnt = 0; aw_got = 1; aw_cyc = cyc;
            end
            if (w_hs) begin
                wr_data_q.push_back(w_hs_data);
                bus.M_WREADY = 1'b0; w_cnt = 0; w_got = 1; w_cyc = cyc;
            end
            if (aw_got && w_got) begin
                bus.M_BVALID = 1'b1; bus.M_BRESP = bresp_val; aw_got = 0; w_got = 0;
            end
            if (bus.M_ARVALID && !bus.M_ARREADY) begin
                if (ar_cnt >= ar_delay) bus.M_ARREADY = 1'b1; else ar_cnt++;
            end
            if (bus.M_AWVALID && !bus.M_AWREADY) begin
                if (aw_cnt >= aw_delay) bus.M_AWREADY = 1'b1; else aw_cnt++;
            end
            if (bus.M_WVALID && !bus.M_WREADY) begin
                if (w_cnt >= w_delay) bus.M_WREADY = 1'b1; else w_cnt++;
            end
            ar_hs = bus.M_ARVALID && bus.M_ARREADY;   ar_hs_addr = bus.M_ARADDR;
            ar_pend = bus.M_ARVALID && !bus.M_ARREADY; ar_pend_addr = bus.M_ARADDR;
            aw_hs = bus.M_AWVALID && bus.M_AWREADY;   aw_hs_addr = bus.M_AWADDR;
            aw_pend = bus.M_AWVALID && !bus.M_AWREADY; aw_pend_addr = bus.M_AWADDR;
            w_hs = bus.M_WVALID && bus.M_WREADY;      w_hs_data = bus.M_WDATA;
            r_hs = bus.M_RVALID && bus.M_RREADY;
            b_hs = bus.M_BVALID && bus.M_BREADY;
        end
    end

    // Reference: signed 64-bit dot product with plain arithmetic.
    function automatic bit [63:0] ref_dot(input bit [31:0] a[$], input bit [31:0] b[$]);
        longint acc = 0;
        for (int i = 0; i < a.size(); i++)
            acc += longint'($signed(a[i])) * longint'($signed(b[i]));
        return acc;
    endfunction

    // Reference: AR order A0,B0,A1,B1,... with 32-bit wrap.
    function automatic void ref_ar(input bit [31:0] ba, input bit [31:0] bb, input int n,
                                   output bit [31:0] q[$]);
        q.delete();
        for (int i = 0; i < n; i++) begin
            q.push_back(ba + 32'(4 * i));
            q.push_back(bb + 32'(4 * i));
        end
    endfunction

    function automatic bit same_q(input bit [31:0] x[$], input bit [31:0] y[$]);
        if (x.size() != y.size()) return 1'b0;
        for (int i = 0; i < x.size(); i++) if (x[i] != y[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic load_vec(input bit [31:0] base, input bit [31:0] d[$]);
        for (int i = 0; i < d.size(); i++) mem[base + 32'(4 * i)] = d[i];
    endtask

    task automatic set_delays(input int ar, input int aw, input int w);
        ar_delay = ar; aw_delay = aw; w_delay = w;
    endtask

    task automatic pulse_start(input bit [31:0] a, input bit [31:0] b, input bit [15:0] n,
                               input bit [31:0] o);
        @(negedge ACLK);
        vec_a_base = a; vec_b_base = b; vec_len = n; out_addr = o; start = 1'b1;
        @(negedge ACLK);
        start = 1'b0;
    endtask

    task automatic wait_done(output bit to);
        to = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (done) begin to = 1'b0; break; end
            @(negedge ACLK);
        end
    endtask

    task automatic run_op(input bit [31:0] a, input bit [31:0] b, input bit [15:0] n,
                          input bit [31:0] o, output bit to);
        ar_log.delete(); wr_addr_q.delete(); wr_data_q.delete();
        excl_viol = 0; stab_viol = 0;
        pulse_start(a, b, n, o);
        wait_done(to);
    endtask

    task automatic test_reset();
        ARESETN = 1'b0;
        repeat (3) @(negedge ACLK);
        total++; if (bus.M_ARVALID !== 1'b0 || bus.M_AWVALID !== 1'b0 || bus.M_WVALID !== 1'b0)
            begin bad++; $display("FAIL reset_valids ar=%b aw=%b w=%b want 0", bus.M_ARVALID, bus.M_AWVALID, bus.M_WVALID); end
        total++; if (bus.M_RREADY !== 1'b0 || bus.M_BREADY !== 1'b0)
            begin bad++; $display("FAIL reset_readys r=%b b=%b want 0", bus.M_RREADY, bus.M_BREADY); end
        ARESETN = 1'b1;
        @(negedge ACLK);
        total++; if ({busy, done, error} !== 3'b000)
            begin bad++; $display("FAIL reset_status got %b want 000", {busy, done, error}); end
        total++; if (result !== 32'd0 || bus.M_ARADDR !== 32'd0 || bus.M_AWADDR !== 32'd0)
            begin bad++; $display("FAIL reset_regs result=%h araddr=%h awaddr=%h want 0", result, bus.M_ARADDR, bus.M_AWADDR); end
    endtask

    task automatic test_basic();
        bit [31:0] a[$] = '{32'd1, 32'd2, 32'd3};
        bit [31:0] b[$] = '{32'd4, 32'd5, 32'd6};
        bit [31:0] exp_ar[$] = '{32'h0, 32'h100, 32'h4, 32'h104, 32'h8, 32'h108};
        bit to;
        set_delays(0, 0, 0);
        load_vec(32'h0, a); load_vec(32'h100, b);
        run_op(32'h0, 32'h100, 16'd3, 32'h1000, to);
        total++; if (to) begin bad++; $display("FAIL basic_timeout done never rose"); end
        total++; if (!same_q(ar_log, exp_ar))
            begin bad++; $display("FAIL basic_ar_order got %0d reads first=%h want 6 reads first=0", ar_log.size(), ar_log.size() ? ar_log[0] : 32'hx); end
        total++; if (wr_addr_q.size() != 1 || wr_addr_q[0] != 32'h1000 || wr_data_q.size() != 1 || wr_data_q[0] != 32'd32)
            begin bad++; $display("FAIL basic_write got %0d writes want one of 32 to 1000", wr_addr_q.size()); end
        total++; if ({busy, done, error} !== 3'b010 || result !== 32'd32)
            begin bad++; $display("FAIL basic_status bde=%b result=%0d want 010 and 32", {busy, done, error}, result); end
    endtask

    task automatic test_zero_len();
        bit to;
        run_op(32'h40, 32'h80, 16'd0, 32'h2000, to);
        total++; if (to || ar_log.size() != 0)
            begin bad++; $display("FAIL zero_len_reads timeout=%b reads=%0d want 0 reads", to, ar_log.size()); end
        total++; if (wr_addr_q.size() != 1 || wr_addr_q[0] != 32'h2000 || wr_data_q.size() != 1 || wr_data_q[0] != 32'd0)
            begin bad++; $display("FAIL zero_len_write got %0d writes want one of 0 to 2000", wr_addr_q.size()); end
        total++; if (done !== 1'b1 || result !== 32'd0)
            begin bad++; $display("FAIL zero_len_done done=%b result=%h want 1, 0", done, result); end
    endtask

    task automatic test_negative();
        bit [31:0] a[$] = '{32'hFFFF_FFFE};
        bit [31:0] b[$] = '{32'd7};
        bit [31:0] exp_w;
        bit to;
        exp_w = ref_dot(a, b);
        load_vec(32'h200, a); load_vec(32'h300, b);
        run_op(32'h200, 32'h300, 16'd1, 32'h3000, to);
        total++; if (to || wr_data_q.size() != 1 || wr_data_q[0] != exp_w || exp_w != 32'hFFFF_FFF2)
            begin bad++; $display("FAIL negative_wdata got %h want %h", wr_data_q.size() ? wr_data_q[0] : 32'hx, 32'hFFFF_FFF2); end
    endtask

    task automatic test_read_error();
        bit [31:0] a[$] = '{32'd3, 32'd4};
        bit [31:0] b[$] = '{32'd5, 32'd6};
        bit to;
        load_vec(32'h500, a); load_vec(32'h600, b);
        err_en = 1'b1; err_addr = 32'h604;
        run_op(32'h500, 32'h600, 16'd2, 32'h4000, to);
        err_en = 1'b0;
        repeat (4) @(negedge ACLK);
        total++; if (to || {busy, done, error} !== 3'b011)
            begin bad++; $display("FAIL rd_err_status bde=%b want 011", {busy, done, error}); end
        total++; if (wr_addr_q.size() != 0 || wr_data_q.size() != 0 || ar_log.size() != 4)
            begin bad++; $display("FAIL rd_err_traffic writes=%0d reads=%0d want 0 and 4", wr_addr_q.size(), ar_log.size()); end
    endtask

    task automatic test_write_error();
        bit [31:0] a[$] = '{32'd11};
        bit [31:0] b[$] = '{32'd3};
        bit to;
        load_vec(32'h700, a); load_vec(32'h780, b);
        bresp_val = 2'b10;
        run_op(32'h700, 32'h780, 16'd1, 32'h4100, to);
        bresp_val = 2'b00;
        total++; if (to || {busy, done, error} !== 3'b011 || result !== 32'd33)
            begin bad++; $display("FAIL wr_err_status bde=%b result=%0d want 011 and 33", {busy, done, error}, result); end
    endtask

    task automatic test_stall();
        bit [31:0] a[$], b[$], exp_ar[$];
        bit [31:0] exp_w;
        bit to;
        for (int i = 0; i < 3; i++) begin a.push_back($urandom); b.push_back($urandom); end
        exp_w = ref_dot(a, b);
        ref_ar(32'h800, 32'h900, 3, exp_ar);
        load_vec(32'h800, a); load_vec(32'h900, b);
        set_delays(3, 3, 0);
        run_op(32'h800, 32'h900, 16'd3, 32'h5000, to);
        set_delays(0, 0, 0);
        total++; if (to || stab_viol != 0)
            begin bad++; $display("FAIL stall_addr_stable timeout=%b violations=%0d want 0", to, stab_viol); end
        total++; if (!(w_cyc < aw_cyc))
            begin bad++; $display("FAIL stall_w_first w at %0d aw at %0d want w earlier", w_cyc, aw_cyc); end
        total++; if (!same_q(ar_log, exp_ar) || result !== exp_w || wr_addr_q.size() != 1 || wr_addr_q[0] != 32'h5000)
            begin bad++; $display("FAIL stall_result got %h want %h reads=%0d", result, exp_w, ar_log.size()); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            bit [31:0] a[$], b[$], exp_ar[$];
            bit [31:0] ba, bb, o, exp_w;
            int n;
            bit to;
            n = $urandom_range(1, 6);
            ba = (it == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            bb = 32'h0001_0000 + 32'(it * 32'h100);
            o = $urandom & 32'hFFFF_FFFC;
            for (int i = 0; i < n; i++) begin a.push_back($urandom); b.push_back($urandom); end
            exp_w = ref_dot(a, b);
            ref_ar(ba, bb, n, exp_ar);
            load_vec(ba, a); load_vec(bb, b);
            set_delays($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            run_op(ba, bb, 16'(n), o, to);
            total++; if (to || !same_q(ar_log, exp_ar))
                begin bad++; $display("FAIL rand%0d_ar timeout=%b reads=%0d want %0d", it, to, ar_log.size(), exp_ar.size()); end
            total++; if (wr_addr_q.size() != 1 || wr_addr_q[0] != o || wr_data_q.size() != 1 || wr_data_q[0] != exp_w)
                begin bad++; $display("FAIL rand%0d_write writes=%0d data=%h want %h at %h", it, wr_data_q.size(), wr_data_q.size() ? wr_data_q[0] : 32'hx, exp_w, o); end
            total++; if (result !== exp_w || error !== 1'b0 || excl_viol != 0 || stab_viol != 0)
                begin bad++; $display("FAIL rand%0d_status result=%h want %h err=%b excl=%0d stab=%0d", it, result, exp_w, error, excl_viol, stab_viol); end
        end
        set_delays(0, 0, 0);
    endtask

    task automatic test_start_ignored();
        bit [31:0] a[$], b[$];
        bit [31:0] exp_w;
        bit to;
        for (int i = 0; i < 4; i++) begin a.push_back($urandom_range(0, 1000)); b.push_back($urandom_range(0, 1000)); end
        exp_w = ref_dot(a, b);
        load_vec(32'hA00, a); load_vec(32'hB00, b);
        ar_log.delete(); wr_addr_q.delete(); wr_data_q.delete();
        pulse_start(32'hA00, 32'hB00, 16'd4, 32'h6000);
        repeat (6) @(negedge ACLK);
        total++; if (busy !== 1'b1)
            begin bad++; $display("FAIL ignore_busy busy=%b want 1", busy); end
        pulse_start(32'hC00, 32'hD00, 16'd1, 32'h7000);
        wait_done(to);
        repeat (3) @(negedge ACLK);
        total++; if (to || ar_log.size() != 8 || wr_addr_q.size() != 1 || wr_addr_q[0] != 32'h6000 || result !== exp_w)
            begin bad++; $display("FAIL ignore_start reads=%0d writes=%0d result=%h want 8, 1, %h", ar_log.size(), wr_addr_q.size(), result, exp_w); end
    endtask

    task automatic test_reset_midop();
        bit [31:0] a[$] = '{32'd9, 32'd1};
        bit [31:0] b[$] = '{32'hFFFF_FFFD, 32'd1};
        bit [31:0] a1[$], b1[$];
        bit [31:0] exp_w;
        bit hit, to;
        load_vec(32'hE00, a); load_vec(32'hF00, b);
        pulse_start(32'hE00, 32'hF00, 16'd2, 32'h8000);
        hit = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.M_RREADY && bus.M_ARADDR == 32'hF00) begin hit = 1'b1; break; end
            @(negedge ACLK);
        end
        total++; if (!hit) begin bad++; $display("FAIL midop_reach never saw B read pending"); end
        ARESETN = 1'b0;
        #1;
        total++; if ({bus.M_ARVALID, bus.M_AWVALID, bus.M_WVALID, bus.M_RREADY, bus.M_BREADY, busy} !== 6'b0)
            begin bad++; $display("FAIL midop_reset_outputs got %b want 000000", {bus.M_ARVALID, bus.M_AWVALID, bus.M_WVALID, bus.M_RREADY, bus.M_BREADY, busy}); end
        repeat (3) @(negedge ACLK);
        ARESETN = 1'b1;
        repeat (2) @(negedge ACLK);
        a1.push_back(a[0]); b1.push_back(b[0]);
        exp_w = ref_dot(a1, b1);
        run_op(32'hE00, 32'hF00, 16'd1, 32'h9000, to);
        total++; if (to || result !== exp_w || wr_addr_q.size() != 1 || wr_addr_q[0] != 32'h9000 || error !== 1'b0)
            begin bad++; $display("FAIL midop_rerun result=%h want %h writes=%0d", result, exp_w, wr_addr_q.size()); end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        test_reset();
        test_basic();
        test_zero_len();
        test_negative();
        test_read_error();
        test_write_error();
        test_stall();
        test_random();
        test_start_ignored();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
